fft_twiddle_rotator: RTL and testbench
======================================

// Module: fft_twiddle_rotator
// PURPOSE
//  Streaming twiddle-multiply stage between radix-2 butterfly passes: multiplies each accepted complex sample by W_N^k = e^(-j2*pi*k/N).
//  k is generated internally from a per-frame sample counter. Uses a quarter-wave table plus quadrant folding.
//  Valid/ready on both sides; 3-stage pipeline with full backpressure.
// PARAMETERS
//  TW_STAGE   7    log2(N), range 3..7; table holds N/4 entries
//  STRIDE     1    k = (count*STRIDE) mod N; STRIDE is a power of two, 1..N/2
// PORTS
//  clk      in   1    single clock, rising edge
//  rst_n    in   1    asynchronous, active-low reset
//  s_valid  in   1    input sample valid
//  s_ready  out  1    input accepted when s_valid & s_ready
//  s_re     in   18   input real part, signed Q1.16 (`REAL_WIDTH)
//  s_im     in   18   input imaginary part, signed Q1.16 (`IMGN_WIDTH)
//  s_last   in   1    last sample of frame
//  m_valid  out  1    output valid
//  m_ready  in   1    downstream ready
//  m_re     out  18   rotated real part, Q1.16
//  m_im     out  18   rotated imaginary part, Q1.16
//  m_last   out  1    s_last delayed with its sample
//  m_idx    out  TW_STAGE  twiddle index k used for this sample
// BEHAVIOUR
//  - Reset: m_valid=0, m_re=0, m_im=0, m_last=0, m_idx=0, counter=0, all pipe valids=0. s_ready=1 after reset.
//  - Pipeline advance: en = m_ready | ~m_valid. s_ready = en. Every stage register updates only when en=1.
//  - Latency: 3 accepted-cycles. S1 registers table lookup and quadrant. S2 registers the 4 products. S3 registers add/sub, round and saturate.
//  - Throughput: 1 sample/clk while m_ready=1. No bubbles and no sample loss under any m_ready pattern.
//  - Counter: advances by 1 per handshake. k = count*STRIDE truncated to TW_STAGE bits, so it wraps N-1 -> 0 naturally.
//  - s_last: on the handshake of a sample with s_last=1, the next count is 0. If s_last and wrap coincide, next k is still 0.
//  - Folding: q = k[MSB:MSB-1], a = k[MSB-2:0]; table gives (re,im) = (cos, -sin) of a.
//    q=0 -> (re,im); q=1 -> (im,-re); q=2 -> (-re,-im); q=3 -> (-im,re).
//  - Table entry 0 = (18'h10000, 0), i.e. exactly 1.0. Negating 1.0 gives 18'h30000, with no overflow.
//  - Arithmetic: 18x18 signed products, 36 bits. Sums are sign-extended to 37 bits.
//    Rounding is round-half-up: add 2^15, then arithmetic shift right by 16.
//    Saturation clamps to [18'h20000, 18'h1FFFF].
//  - Mid-frame reset: in-flight samples are discarded and the counter returns to 0. The next accepted sample uses k=0.
//  - m_* outputs stay stable while m_valid=1 and m_ready=0.
// CONFIGURATION
//  - FFT_TW_CONJ_EN defined:
//    - Adds input port inv (1 bit).
//    - inv is sampled on the first handshake of each frame (count==0) and held for that frame.
//    - inv=1 uses conj(W), i.e. im is negated after folding, for the IFFT direction.
//  - FFT_TW_CONJ_EN undefined: no inv port; forward twiddles only.
// STRUCTURE
//  - Package fft_tw_pkg:
//    - typedef cplx_t {logic signed [17:0] re, im;}
//    - localparam TW_ONE = 18'h10000
//    - the quarter-wave cos/-sin table for N=128, 32 entries. Smaller N index it with stride 128/N.
//    - sat18() rounding/saturation function.
//  - Sub-module fft_tw_rom: combinational quarter-wave lookup + quadrant fold (+ conj with FFT_TW_CONJ_EN).
//    Registered into S1 by this block.
// TESTING
//  - N=128, input (18'h10000,0), k=0 -> m_re=18'h10000, m_im=0, appears 3 clk after the handshake.
//  - k=32 (W=-j), input (18'h10000,0) -> (0, 18'h30000); k=64 -> (18'h30000, 0).
//  - k=64, input (18'h20000,18'h20000) -> saturates to (18'h1FFFF,18'h1FFFF).
//  - Stream 10 samples, hold m_ready=0 for 5 clk mid-stream:
//    - s_ready=0 during the stall; m_* held stable; all 10 outputs arrive in order with m_idx 0..9.
//  - 130 samples without s_last -> m_idx ...,126,127,0,1.
//    Next frame: s_last on sample 5, then the following sample has m_idx=0.
//  - With FFT_TW_CONJ_EN and inv=1: k=32, input (18'h10000,0) -> (0,18'h10000).
//    Assert rst_n low mid-frame -> m_valid=0 immediately; first output after reset has m_idx=0.

Source files
------------

// File: rtl/fft_tw_pkg.sv
// rtl/fft_tw_pkg.sv - shared types, quarter-wave twiddle table and rounding for the twiddle rotator
`ifndef REAL_WIDTH
`define REAL_WIDTH 18
`endif
`ifndef IMGN_WIDTH
`define IMGN_WIDTH 18
`endif

package fft_tw_pkg;

    localparam int DATA_W       = 18;
    localparam int PROD_W       = 36;
    localparam int SUM_W        = 37;
    localparam int TW_MAX_STAGE = 7;

    localparam logic signed [DATA_W-1:0] TW_ONE = 18'sh10000;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    // cos(2*pi*i/128) scaled by 2^16, i = 0..32 (entry 32 closes the quarter for the sine side)
    function automatic logic [16:0] cos_q(input logic [5:0] i);
        logic [16:0] v;
        case (i)
            6'd0:    v = TW_ONE[16:0];
            6'd1:    v = 17'd65457;
            6'd2:    v = 17'd65220;
            6'd3:    v = 17'd64827;
            6'd4:    v = 17'd64277;
            6'd5:    v = 17'd63572;
            6'd6:    v = 17'd62714;
            6'd7:    v = 17'd61705;
            6'd8:    v = 17'd60547;
            6'd9:    v = 17'd59244;
            6'd10:   v = 17'd57798;
            6'd11:   v = 17'd56212;
            6'd12:   v = 17'd54491;
            6'd13:   v = 17'd52639;
            6'd14:   v = 17'd50660;
            6'd15:   v = 17'd48559;
            6'd16:   v = 17'd46341;
            6'd17:   v = 17'd44011;
            6'd18:   v = 17'd41576;
            6'd19:   v = 17'd39040;
            6'd20:   v = 17'd36410;
            6'd21:   v = 17'd33692;
            6'd22:   v = 17'd30893;
            6'd23:   v = 17'd28020;
            6'd24:   v = 17'd25080;
            6'd25:   v = 17'd22078;
            6'd26:   v = 17'd19024;
            6'd27:   v = 17'd15924;
            6'd28:   v = 17'd12785;
            6'd29:   v = 17'd9616;
            6'd30:   v = 17'd6424;
            6'd31:   v = 17'd3216;
            default: v = 17'd0;
        endcase
        return v;
    endfunction

    // Quarter-wave entry a of the N=128 table: (cos, -sin); sin(a) is read as cos(32-a)
    function automatic cplx_t tw_quarter(input logic [4:0] a);
        cplx_t t;
        t.re = $signed({1'b0, cos_q({1'b0, a})});
        t.im = -$signed({1'b0, cos_q(6'd32 - {1'b0, a})});
        return t;
    endfunction

    // Round half up at bit 16 and clamp to the Q1.16 range
    function automatic logic signed [DATA_W-1:0] sat18(input logic signed [SUM_W-1:0] sum);
        logic signed [SUM_W-1:0] r;
        r = (sum + 37'sd32768) >>> 16;
        if (r > 37'sd131071) begin
            return 18'sh1FFFF;
        end else if (r < -37'sd131072) begin
            return 18'sh20000;
        end else begin
            return r[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/fft_tw_rom.sv
// rtl/fft_tw_rom.sv - combinational quarter-wave lookup with quadrant fold; conj input under FFT_TW_CONJ_EN
module fft_tw_rom
    import fft_tw_pkg::*;
#(
    parameter int TW_STAGE = 7
) (
    input  logic [TW_STAGE-1:0] k,
`ifdef FFT_TW_CONJ_EN
    input  logic                conj,
`endif
    output cplx_t               w
);

    // Smaller transforms step through the 128-point table with stride 128/N
    localparam int SHIFT = TW_MAX_STAGE - TW_STAGE;

    logic [1:0]          q;
    logic [TW_STAGE-3:0] a;
    logic [4:0]          idx;
    cplx_t               base;
    cplx_t               fold;

    // Split k into quadrant and in-quadrant angle, look up, then rotate by q*(-j)
    always_comb begin
        q    = k[TW_STAGE-1 -: 2];
        a    = k[TW_STAGE-3:0];
        idx  = 5'(a) << SHIFT;
        base = tw_quarter(idx);
        fold = base;
        case (q)
            2'd0: begin
                fold.re = base.re;
                fold.im = base.im;
            end
            2'd1: begin
                fold.re = base.im;
                fold.im = -base.re;
            end
            2'd2: begin
                fold.re = -base.re;
                fold.im = -base.im;
            end
            default: begin
                fold.re = -base.im;
                fold.im = base.re;
            end
        endcase
        w = fold;
`ifdef FFT_TW_CONJ_EN
        if (conj) begin
            w.im = -fold.im;
        end
`endif
    end

endmodule

// File: rtl/fft_twiddle_rotator.sv
// rtl/fft_twiddle_rotator.sv - streaming 3-stage twiddle multiplier; FFT_TW_CONJ_EN adds the inv port
module fft_twiddle_rotator
    import fft_tw_pkg::*;
#(
    parameter int TW_STAGE = 7,
    parameter int STRIDE   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic signed [`REAL_WIDTH-1:0] s_re,
    input  logic signed [`IMGN_WIDTH-1:0] s_im,
    input  logic                          s_last,
`ifdef FFT_TW_CONJ_EN
    input  logic                          inv,
`endif
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic signed [`REAL_WIDTH-1:0] m_re,
    output logic signed [`IMGN_WIDTH-1:0] m_im,
    output logic                          m_last,
    output logic [TW_STAGE-1:0]           m_idx
);

    localparam int STRIDE_LOG2 = $clog2(STRIDE);

    logic                en;
    logic                hs;
    logic [TW_STAGE-1:0] count;
    logic [TW_STAGE-1:0] k;
    cplx_t               w;

    logic                v1;
    logic                l1;
    logic [TW_STAGE-1:0] i1;
    cplx_t               x1;
    cplx_t               w1;

    logic                     v2;
    logic                     l2;
    logic [TW_STAGE-1:0]      i2;
    logic signed [PROD_W-1:0] p_rr;
    logic signed [PROD_W-1:0] p_ii;
    logic signed [PROD_W-1:0] p_ri;
    logic signed [PROD_W-1:0] p_ir;

    // The whole pipe moves as one unit whenever the output slot is free or being drained
    always_comb begin
        en      = m_ready | ~m_valid;
        s_ready = en;
        hs      = s_valid & en;
        k       = count << STRIDE_LOG2;
    end

    // Sample counter within the frame; s_last restarts the frame at k=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (hs) begin
            count <= s_last ? '0 : count + TW_STAGE'(1);
        end
    end

`ifdef FFT_TW_CONJ_EN
    logic inv_hold;
    logic conj_now;

    // The frame's direction is taken from its first sample and held until the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_hold <= 1'b0;
        end else if (hs && count == '0) begin
            inv_hold <= inv;
        end
    end

    // First sample of a frame uses inv directly, the rest use the held value
    always_comb begin
        conj_now = (count == '0) ? inv : inv_hold;
    end

    fft_tw_rom #(.TW_STAGE(TW_STAGE)) u_rom (
        .k    (k),
        .conj (conj_now),
        .w    (w)
    );
`else
    fft_tw_rom #(.TW_STAGE(TW_STAGE)) u_rom (
        .k (k),
        .w (w)
    );
`endif

    // S1: capture the sample alongside its folded twiddle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            l1 <= 1'b0;
            i1 <= '0;
            x1 <= '0;
            w1 <= '0;
        end else if (en) begin
            v1    <= s_valid;
            l1    <= s_last;
            i1    <= k;
            x1.re <= s_re;
            x1.im <= s_im;
            w1    <= w;
        end
    end

    // S2: the four partial products of the complex multiply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            l2   <= 1'b0;
            i2   <= '0;
            p_rr <= '0;
            p_ii <= '0;
            p_ri <= '0;
            p_ir <= '0;
        end else if (en) begin
            v2   <= v1;
            l2   <= l1;
            i2   <= i1;
            p_rr <= PROD_W'(x1.re) * PROD_W'(w1.re);
            p_ii <= PROD_W'(x1.im) * PROD_W'(w1.im);
            p_ri <= PROD_W'(x1.re) * PROD_W'(w1.im);
            p_ir <= PROD_W'(x1.im) * PROD_W'(w1.re);
        end
    end

    // S3: combine products, round and saturate into the output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_idx   <= '0;
            m_re    <= '0;
            m_im    <= '0;
        end else if (en) begin
            m_valid <= v2;
            m_last  <= l2;
            m_idx   <= i2;
            m_re    <= sat18(SUM_W'(p_rr) - SUM_W'(p_ii));
            m_im    <= sat18(SUM_W'(p_ri) + SUM_W'(p_ir));
        end
    end

endmodule

// File: tb/tb_fft_twiddle_rotator.sv
// tb/tb_fft_twiddle_rotator.sv - randomized self-checking bench for fft_twiddle_rotator
module tb_fft_twiddle_rotator;

    localparam int  TW_STAGE = 7;
    localparam int  STRIDE   = 1;
    localparam int  NN       = 1 << TW_STAGE;
    localparam real PI       = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0;
    logic s_last = 1'b0;
    logic m_ready = 1'b1;
    logic signed [17:0] s_re = '0;
    logic signed [17:0] s_im = '0;
    logic s_ready;
    logic m_valid;
    logic m_last;
    logic signed [17:0] m_re;
    logic signed [17:0] m_im;
    logic [TW_STAGE-1:0] m_idx;
`ifdef FFT_TW_CONJ_EN
    logic inv = 1'b0;
`endif

    fft_twiddle_rotator #(.TW_STAGE(TW_STAGE), .STRIDE(STRIDE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_re    (s_re),
        .s_im    (s_im),
        .s_last  (s_last),
`ifdef FFT_TW_CONJ_EN
        .inv     (inv),
`endif
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_re    (m_re),
        .m_im    (m_im),
        .m_last  (m_last),
        .m_idx   (m_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint re;
        longint im;
        bit     last;
        int     idx;
        bit     lat;
        int     cyc;
        bit     first;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mcnt = 0;
    bit   minv = 1'b0;
    bit   lat_mode = 1'b0;
    bit   first_after_rst = 1'b0;
    int   rmode = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic longint rnd(input real x);
        if (x >= 0.0) return longint'($floor(x + 0.5));
        return -longint'($floor(-x + 0.5));
    endfunction

    function automatic longint clamp(input longint v);
        if (v > 131071) return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    // Exact rotation of (xr,xi) by e^(-j2pi k/N) (or its conjugate) in Q1.16
    function automatic void model(input int k, input longint xr, input longint xi, input bit cj,
                                  output longint er, output longint ei);
        real    th;
        longint wr;
        longint wi;
        th = 2.0 * PI * real'(k) / real'(NN);
        wr = rnd($cos(th) * 65536.0);
        wi = rnd(-$sin(th) * 65536.0);
        if (cj) wi = -wi;
        er = clamp((xr * wr - xi * wi + 32768) >>> 16);
        ei = clamp((xr * wi + xi * wr + 32768) >>> 16);
    endfunction

    // Downstream ready pattern: always, random, or held low
    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(0, 99) < 60);
            default: m_ready = 1'b0;
        endcase
    end

    // Scoreboard: push expectations on input handshakes, compare on output handshakes
    initial begin : monitor
        exp_t   e;
        int     k;
        bit     stall_prev;
        longint p_re, p_im, p_idx, p_last;
        stall_prev = 1'b0;
        p_re = 0; p_im = 0; p_idx = 0; p_last = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", m_valid, 1);
                    check("hold_re", m_re, p_re);
                    check("hold_im", m_im, p_im);
                    check("hold_idx", m_idx, p_idx);
                    check("hold_last", m_last, p_last);
                end
                if (m_valid && !m_ready) check("s_ready_stall", s_ready, 0);
                if (!m_valid) check("s_ready_free", s_ready, 1);
                stall_prev = m_valid && !m_ready;
                p_re = m_re; p_im = m_im; p_idx = m_idx; p_last = m_last;
                if (m_valid && m_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output actual=idx %0d required=no output", m_idx);
                    end else begin
                        e = q.pop_front();
                        check("m_re", m_re, e.re);
                        check("m_im", m_im, e.im);
                        check("m_idx", m_idx, e.idx);
                        check("m_last", m_last, e.last);
                        if (e.lat) check("latency", cyc - e.cyc, 3);
                        if (e.first) check("idx_after_reset", m_idx, 0);
                    end
                end
                if (s_valid && s_ready) begin
`ifdef FFT_TW_CONJ_EN
                    if (mcnt == 0) minv = inv;
`endif
                    k = (mcnt * STRIDE) % NN;
                    model(k, s_re, s_im, minv, e.re, e.im);
                    e.last  = s_last;
                    e.idx   = k;
                    e.lat   = lat_mode;
                    e.cyc   = cyc;
                    e.first = first_after_rst;
                    first_after_rst = 1'b0;
                    q.push_back(e);
                    mcnt = s_last ? 0 : (mcnt + 1) % NN;
                end
            end
        end
    end

    task automatic send(input logic signed [17:0] re, input logic signed [17:0] im, input logic last);
        int n;
        bit ok;
        n = 0;
        s_valid = 1'b1;
        s_re    = re;
        s_im    = im;
        s_last  = last;
`ifdef FFT_TW_CONJ_EN
        inv = 1'($urandom_range(0, 1));
`endif
        do begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not accepted required=accepted within 200 cycles");
        end
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [17:0] rand18();
        case ($urandom_range(0, 9))
            0:       return 18'sh20000;
            1:       return 18'sh1FFFF;
            2:       return 18'sh10000;
            default: return 18'($urandom);
        endcase
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : main
        longint er, ei;
        int     n;

        model(0, 65536, 0, 1'b0, er, ei);
        check("pin_k0_re", er, 65536);
        check("pin_k0_im", ei, 0);
        model(32, 65536, 0, 1'b0, er, ei);
        check("pin_k32_re", er, 0);
        check("pin_k32_im", ei, -65536);
        model(64, 65536, 0, 1'b0, er, ei);
        check("pin_k64_re", er, -65536);
        check("pin_k64_im", ei, 0);
        model(64, -131072, -131072, 1'b0, er, ei);
        check("pin_sat_re", er, 131071);
        check("pin_sat_im", ei, 131071);
`ifdef FFT_TW_CONJ_EN
        model(32, 65536, 0, 1'b1, er, ei);
        check("pin_conj_re", er, 0);
        check("pin_conj_im", ei, 65536);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_re", m_re, 0);
        check("rst_m_im", m_im, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_idx", m_idx, 0);
        check("rst_s_ready", s_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_s_ready", s_ready, 1);

        lat_mode = 1'b1;
        for (int i = 0; i <= 64; i++) send(18'sh10000, 18'sh00000, i == 64);
        for (int i = 0; i <= 64; i++) begin
            if (i == 64) send(18'sh20000, 18'sh20000, 1'b1);
            else send(rand18(), rand18(), 1'b0);
        end
        idle();

        lat_mode = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send(rand18(), rand18(), i == 9);
                idle();
            end
            begin
                repeat (4) @(posedge clk);
                rmode = 2;
                repeat (5) @(posedge clk);
                rmode = 0;
            end
        join

        lat_mode = 1'b1;
        for (int i = 0; i < 130; i++) send(rand18(), rand18(), 1'b0);
        for (int i = 0; i < 8; i++) send(rand18(), rand18(), i == 4);
        idle();

        lat_mode = 1'b0;
        rmode = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else send(rand18(), rand18(), $urandom_range(0, 19) == 0);
        end
        idle();
        rmode = 0;
        repeat (6) @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) send(rand18(), rand18(), 1'b0);
        #2;
        rst_n = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        q.delete();
        mcnt = 0;
        minv = 1'b0;
        #1;
        check("async_rst_m_valid", m_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        first_after_rst = 1'b1;
        lat_mode = 1'b1;
        for (int i = 0; i < 3; i++) send(rand18(), rand18(), 1'b0);
        idle();

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
